// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - shared MIPS opcode, format and error-code definitions
package mips_isa_pkg;

    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] JUMP       = 6'h02;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_ILLEGAL
    } instr_fmt_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    // Only the opcodes control_unit decodes are legal; everything else is rejected.
    function automatic instr_fmt_e opcode_format(input logic [5:0] opcode);
        case (opcode)
            ALU_R:                                      return FMT_R;
            ADDI, BRANCH_EQ, LOAD_WORD, STORE_WORD:     return FMT_I;
            JUMP:                                       return FMT_J;
            default:                                    return FMT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/instr_format_pack.sv
// rtl/instr_format_pack.sv - combinational packer from decoded fields to a 32-bit MIPS word
module instr_format_pack
    import mips_isa_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output instr_fmt_e  fmt
);

    always_comb begin
        fmt  = opcode_format(opcode);
        word = 32'h0;
        case (fmt)
            FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams field bundles into encoded words written to instruction memory
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       packed_word;
    instr_fmt_e        fmt;

    instr_format_pack u_pack (
        .opcode (in_opcode),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (packed_word),
        .fmt    (fmt)
    );

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERROR);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            word_count <= '0;
            err_code   <= ERR_NONE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (fmt == FMT_ILLEGAL) begin
                            err_code <= ERR_ILLEGAL;
                            state    <= S_ERROR;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ptr;
                            imem_wdata <= packed_word;
                            word_count <= word_count + WC_ONE;
                            if (in_last) begin
                                state <= S_DONE;
                            end else if (ptr == PTR_MAX) begin
                                // Last slot is still written; the pointer is held rather than wrapped.
                                err_code <= ERR_OVERFLOW;
                                state    <= S_ERROR;
                            end else begin
                                ptr <= ptr + PTR_ONE;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state      <= S_LOAD;
                        ptr        <= '0;
                        word_count <= '0;
                        err_code   <= ERR_NONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        in_ready, imem_we, busy, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [1:0]  s_err_code;
    logic [2:0]  s_word_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .word_count(word_count)
    );

    instr_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .busy(s_busy),
        .done(s_done), .err(s_err), .err_code(s_err_code), .word_count(s_word_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [5:0] fn, input logic last);
        in_opcode = 6'h00; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_funct = fn;
        in_imm = 16'h0; in_target = 26'h0; in_last = last;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic last);
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = 5'h0; in_shamt = 5'h0; in_funct = 6'h0;
        in_imm = imm; in_target = 26'h0; in_last = last;
    endtask

    task automatic set_j(input logic [25:0] tgt, input logic last);
        in_opcode = 6'h02; in_rs = 5'h0; in_rt = 5'h0; in_rd = 5'h0; in_shamt = 5'h0;
        in_funct = 6'h0; in_imm = 16'h0; in_target = tgt; in_last = last;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        set_r(5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
        #2;
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, word_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b code=%0d wc=%0d exp all zero",
                     in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, word_count);
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_r_type();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL r_start_ready got rdy=%b busy=%b exp 1 1", in_ready, busy);
        end
        set_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00221820) begin
            failures++;
            $display("FAIL r_write got we=%b addr=%h data=%h exp 1 00 00221820", imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (done !== 1'b1 || word_count !== 9'd1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL r_done got done=%b wc=%0d rdy=%b exp 1 1 0", done, word_count, in_ready);
        end
        tick();
        checks++;
        if (imem_we !== 1'b0 || imem_wdata !== 32'h00221820) begin
            failures++;
            $display("FAIL r_strobe_one_cycle got we=%b data=%h exp 0 00221820", imem_we, imem_wdata);
        end
    endtask

    task automatic test_stream_mixed();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'h8D280004; exp_data[1] = 32'h1022FFFF;
        exp_data[2] = 32'h08000010; exp_data[3] = 32'hAD280000;
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || word_count !== 9'd0) begin
            failures++;
            $display("FAIL b2b_restart got rdy=%b done=%b wc=%0d exp 1 0 0", in_ready, done, word_count);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_i(6'h23, 5'd9, 5'd8, 16'h0004, 1'b0);
                1: set_i(6'h04, 5'd1, 5'd2, 16'hFFFF, 1'b0);
                2: set_j(26'h10, 1'b0);
                default: set_i(6'h2B, 5'd9, 5'd8, 16'h0000, 1'b1);
            endcase
            tick();
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== k[7:0] || imem_wdata !== exp_data[k]) begin
                failures++;
                $display("FAIL stream_word%0d got we=%b addr=%h data=%h exp 1 %h %h",
                         k, imem_we, imem_addr, imem_wdata, k[7:0], exp_data[k]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || word_count !== 9'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stream_done got done=%b wc=%0d rdy=%b exp 1 4 0", done, word_count, in_ready);
        end
    endtask

    task automatic test_illegal_opcode();
        pulse_start();
        in_valid = 1'b1;
        set_i(6'h08, 5'd1, 5'd1, 16'h0005, 1'b0);
        tick();
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h20210005) begin
            failures++;
            $display("FAIL illegal_first got we=%b addr=%h data=%h exp 1 00 20210005", imem_we, imem_addr, imem_wdata);
        end
        set_i(6'h3F, 5'd1, 5'd1, 16'h0001, 1'b1);
        tick();
        checks++;
        if (imem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'd1 || word_count !== 9'd1 ||
            in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL illegal_err got we=%b err=%b code=%0d wc=%0d rdy=%b done=%b exp 0 1 1 1 0 0",
                     imem_we, err, err_code, word_count, in_ready, done);
        end
        set_i(6'h23, 5'd2, 5'd3, 16'h0008, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || word_count !== 9'd1 || err_code !== 2'd1 || imem_wdata !== 32'h20210005) begin
            failures++;
            $display("FAIL illegal_ignore got we=%b wc=%0d code=%0d data=%h exp 0 1 1 20210005",
                     imem_we, word_count, err_code, imem_wdata);
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_i(6'h08, 5'd0, 5'd4, k[15:0], 1'b0);
            tick();
            if (k < 4) begin
                checks++;
                if (s_imem_we !== 1'b1 || s_imem_addr !== k[1:0] || s_imem_wdata !== {16'h2004, k[15:0]}) begin
                    failures++;
                    $display("FAIL ovf_write%0d got we=%b addr=%0d data=%h exp 1 %0d %h",
                             k, s_imem_we, s_imem_addr, s_imem_wdata, k, {16'h2004, k[15:0]});
                end
            end else begin
                checks++;
                if (s_imem_we !== 1'b0 || s_word_count !== 3'd4) begin
                    failures++;
                    $display("FAIL ovf_fifth got we=%b wc=%0d exp 0 4", s_imem_we, s_word_count);
                end
            end
            if (k == 3) begin
                checks++;
                if (s_err !== 1'b1 || s_err_code !== 2'd2 || s_word_count !== 3'd4 || s_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_err got err=%b code=%0d wc=%0d rdy=%b exp 1 2 4 0",
                             s_err, s_err_code, s_word_count, s_in_ready);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_restart();
        pulse_start();
        in_valid = 1'b1;
        set_i(6'h23, 5'd1, 5'd2, 16'h0010, 1'b0);
        tick();
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, word_count} !== '0) begin
            failures++;
            $display("FAIL async_reset got rdy=%b we=%b addr=%h data=%h busy=%b wc=%0d exp all zero",
                     in_ready, imem_we, imem_addr, imem_wdata, busy, word_count);
        end
        tick();
        tick();
        checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_hold got we=%b busy=%b exp 0 0", imem_we, busy);
        end
        @(negedge clk);
        arst_n = 1'b1;
        in_valid = 1'b0;
        tick();
        pulse_start();
        in_valid = 1'b1;
        set_r(5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 1'b0);
        tick();
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00853080) begin
            failures++;
            $display("FAIL restart_addr0 got we=%b addr=%h data=%h exp 1 00 00853080", imem_we, imem_addr, imem_wdata);
        end
        start = 1'b1;
        set_j(26'h3FFFFFF, 1'b0);
        tick();
        start = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h0BFFFFFF || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_load got we=%b addr=%h data=%h busy=%b exp 1 01 0BFFFFFF 1",
                     imem_we, imem_addr, imem_wdata, busy);
        end
        set_i(6'h2B, 5'd3, 5'd7, 16'h8000, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (imem_addr !== 8'd2 || imem_wdata !== 32'hAC678000 || done !== 1'b1 || word_count !== 9'd3) begin
            failures++;
            $display("FAIL restart_done got addr=%h data=%h done=%b wc=%0d exp 02 AC678000 1 3",
                     imem_addr, imem_wdata, done, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_stream_mixed();
        test_illegal_opcode();
        test_overflow();
        test_reset_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
